// File: rtl/circ_shift_pkg.sv
// Shared helpers for the circular shift unit: effective rotation distance and
// a bit-by-bit reference rotator used by models outside the datapath.
package circ_shift_pkg;

  localparam int REF_W = 64;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_e;

  typedef struct packed {
    logic             vld;
    logic             mismatch;
  } rot_flags_t;

  function automatic int eff_dist(input int n, input int s);
    if (n < 1) return 0;
    return s % n;
  endfunction

  // Only bits [n-1:0] of the argument and result are meaningful.
  function automatic logic [REF_W-1:0] rot_ref(input logic [REF_W-1:0] a,
                                                input int n,
                                                input int s,
                                                input rot_dir_e dir);
    logic [REF_W-1:0] r;
    int se;
    r  = '0;
    se = eff_dist(n, s);
    for (int i = 0; i < n; i++) begin
      if (dir == ROT_LEFT) r[i] = a[(i - se + n) % n];
      else                 r[i] = a[(i + se) % n];
    end
    return r;
  endfunction

endpackage

// File: rtl/circ_rot_core.sv
// Combinational constant-distance rotator: left by concatenation, left and
// right by OR of two logical shifts.
module circ_rot_core
  import circ_shift_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 3
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] rotl_cat,
  output logic [N-1:0] rotl_or,
  output logic [N-1:0] rotr_or
);

  localparam int SE = eff_dist(N, S);

  generate
    if (N == 1 || SE == 0) begin : g_identity
      // A zero distance would need an empty slice and a shift by N.
      assign rotl_cat = a;
      assign rotl_or  = a;
      assign rotr_or  = a;
    end else begin : g_rotate
      assign rotl_cat = {a[N-1-SE:0], a[N-1:N-SE]};
      assign rotl_or  = (a << SE) | (a >> (N - SE));
      assign rotr_or  = (a >> SE) | (a << (N - SE));
    end
  endgenerate

endmodule

// File: rtl/circular_shift_unit.sv
// One-stage registered rotator with valid qualifier and a self-check flag
// comparing the two independently built left rotations.
module circular_shift_unit
  import circ_shift_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [N-1:0] a,
  output logic         out_vld,
  output logic [N-1:0] rotl_cat,
  output logic [N-1:0] rotl_or,
  output logic [N-1:0] rotr_or,
  output logic         rotl_mismatch
);

  logic [N-1:0] rotl_cat_next;
  logic [N-1:0] rotl_or_next;
  logic [N-1:0] rotr_or_next;
  logic         mismatch_next;
  rot_flags_t   flags_q;

  circ_rot_core #(
    .N (N),
    .S (S)
  ) u_core (
    .a        (a),
    .rotl_cat (rotl_cat_next),
    .rotl_or  (rotl_or_next),
    .rotr_or  (rotr_or_next)
  );

  assign mismatch_next = (rotl_cat_next != rotl_or_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rotl_cat <= '0;
      rotl_or  <= '0;
      rotr_or  <= '0;
    end else if (in_vld) begin
      rotl_cat <= rotl_cat_next;
      rotl_or  <= rotl_or_next;
      rotr_or  <= rotr_or_next;
    end
  end

  // Flag is only meaningful alongside a fresh word, so it drops on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q.vld      <= in_vld;
      flags_q.mismatch <= in_vld & mismatch_next;
    end
  end

  assign out_vld       = flags_q.vld;
  assign rotl_mismatch = flags_q.mismatch;

endmodule

// File: tb/tb_circular_shift_unit.sv
module tb_circular_shift_unit;
  import circ_shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] a;

  logic       ov3, ov0, ov8, ov11;
  logic [7:0] lc3, lo3, ro3, lc0, lo0, ro0, lc8, lo8, ro8, lc11, lo11, ro11;
  logic       mm3, mm0, mm8, mm11;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] l;
    logic [7:0] r;
  } vec_t;

  vec_t       sb_q[$];
  vec_t       last;
  vec_t       vecs[8];

  always #5 clk = ~clk;

  circular_shift_unit #(.N(8), .S(3)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .a(a), .out_vld(ov3),
    .rotl_cat(lc3), .rotl_or(lo3), .rotr_or(ro3), .rotl_mismatch(mm3));
  circular_shift_unit #(.N(8), .S(0)) dut_s0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .a(a), .out_vld(ov0),
    .rotl_cat(lc0), .rotl_or(lo0), .rotr_or(ro0), .rotl_mismatch(mm0));
  circular_shift_unit #(.N(8), .S(8)) dut_s8 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .a(a), .out_vld(ov8),
    .rotl_cat(lc8), .rotl_or(lo8), .rotr_or(ro8), .rotl_mismatch(mm8));
  circular_shift_unit #(.N(8), .S(11)) dut_s11 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .a(a), .out_vld(ov11),
    .rotl_cat(lc11), .rotl_or(lo11), .rotr_or(ro11), .rotl_mismatch(mm11));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_data(input string tag, input vec_t e, input logic mm_exp);
    chk({tag, " s3 rotl_cat"}, lc3, e.l);
    chk({tag, " s3 rotl_or"},  lo3, e.l);
    chk({tag, " s3 rotr_or"},  ro3, e.r);
    chk({tag, " s3 mismatch"}, {7'd0, mm3}, {7'd0, mm_exp});
    chk({tag, " s0 rotl_cat"}, lc0, e.a);
    chk({tag, " s0 rotl_or"},  lo0, e.a);
    chk({tag, " s0 rotr_or"},  ro0, e.a);
    chk({tag, " s8 rotl_cat"}, lc8, e.a);
    chk({tag, " s8 rotl_or"},  lo8, e.a);
    chk({tag, " s8 rotr_or"},  ro8, e.a);
    chk({tag, " s11 rotl_cat"}, lc11, e.l);
    chk({tag, " s11 rotl_or"},  lo11, e.l);
    chk({tag, " s11 rotr_or"},  ro11, e.r);
    chk({tag, " aux mismatch"}, {5'd0, mm0, mm8, mm11}, 8'd0);
  endtask

  task automatic chk_vld(input string tag, input logic exp);
    chk({tag, " out_vld"}, {4'd0, ov3, ov0, ov8, ov11}, {4'd0, {4{exp}}});
  endtask

  // Drive one cycle; expected values for a valid word are pushed now and
  // popped when the registered result is sampled 1ns after the next edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic [7:0] el, input logic [7:0] er);
    vec_t e;
    @(negedge clk);
    in_vld = v;
    a      = d;
    if (v) begin
      e.a = d; e.l = el; e.r = er;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk_vld(tag, v);
    if (v) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL %s scoreboard: queue empty, expected one entry", tag);
      end else begin
        e = sb_q.pop_front();
        chk_data(tag, e, 1'b0);
        last = e;
      end
    end else begin
      chk_data(tag, last, 1'b0);
    end
  endtask

  task automatic step_ref(input string tag, input logic [7:0] d);
    logic [63:0] l, r;
    l = rot_ref({56'd0, d}, 8, 3, ROT_LEFT);
    r = rot_ref({56'd0, d}, 8, 3, ROT_RIGHT);
    step(tag, 1'b1, d, l[7:0], r[7:0]);
  endtask

  initial begin
    vecs[0] = '{8'b10110101, 8'b10101101, 8'b10110110};
    vecs[1] = '{8'b10000000, 8'b00000100, 8'b00010000};
    vecs[2] = '{8'b00000001, 8'b00001000, 8'b00100000};
    vecs[3] = '{8'b00010000, 8'b10000000, 8'b00000010};
    vecs[4] = '{8'b00000000, 8'b00000000, 8'b00000000};
    vecs[5] = '{8'b11111111, 8'b11111111, 8'b11111111};
    vecs[6] = '{8'b01110000, 8'b10000011, 8'b00001110};
    vecs[7] = '{8'b11010001, 8'b10001110, 8'b00111010};
    last = '{8'd0, 8'd0, 8'd0};

    rst = 1'b1; in_vld = 1'b0; a = 8'h00;
    #12;
    chk_vld("reset", 1'b0);
    chk_data("reset", last, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single word, then back-to-back walking ones and edge patterns.
    step("single", 1'b1, vecs[0].a, vecs[0].l, vecs[0].r);
    step("idle0", 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 1; i < 8; i++)
      step($sformatf("vec%0d", i), 1'b1, vecs[i].a, vecs[i].l, vecs[i].r);

    // Idle with changing input: data holds, out_vld low.
    step("hold1", 1'b0, 8'h3C, 8'h00, 8'h00);
    step("hold2", 1'b0, 8'hC3, 8'h00, 8'h00);

    // Async reset mid-stream, between clock edges.
    step("pre_rst", 1'b1, vecs[0].a, vecs[0].l, vecs[0].r);
    @(negedge clk);
    in_vld = 1'b1;
    a      = 8'h5A;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    last = '{8'd0, 8'd0, 8'd0};
    chk_vld("async_rst", 1'b0);
    chk_data("async_rst", last, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    rst    = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk_vld("post_rst", 1'b0);
    chk_data("post_rst", last, 1'b0);

    for (int i = 0; i < 24; i++)
      step_ref($sformatf("rand%0d", i), 8'($urandom_range(0, 255)));

    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/circular_shift_unit.md
Name: circular_shift_unit

Overview:
- Registered constant-distance rotator: takes an N-bit word and produces its circular left rotation and circular right rotation by S bits.
- The left rotation is computed two independent ways: slice/concatenate, and OR of two logical shifts. Both results are exposed, plus a mismatch flag, for datapath self-checking.
- Sits in the arithmetic/pipelining datapath as a one-stage pipeline element with a valid qualifier.

Parameters:
- N, default 8, data width in bits; N ≥ 1.
- S, default 3, rotation distance in bits; any non-negative integer, effective distance is SE = S mod N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_vld  input  1  input word valid.
- a  input  N  input word.
- out_vld  output  1  registered valid, in_vld delayed by one cycle.
- rotl_cat  output  N  left rotation of a by SE, slice/concatenate form.
- rotl_or  output  N  left rotation of a by SE, shift-OR form.
- rotr_or  output  N  right rotation of a by SE, shift-OR form.
- rotl_mismatch  output  1  high when rotl_cat and rotl_or differ (error indicator; never expected high).

Behaviour:
- Reset (async assert, sync release): out_vld=0, rotl_cat=0, rotl_or=0, rotr_or=0, rotl_mismatch=0.
- Left rotation, concatenate form: result = {a[N-1-SE:0], a[N-1:N-SE]}.
  - Bit i of the result = a[(i-SE) mod N].
  - MSBs of a wrap to the LSB end.
- Left rotation, OR form: result = (a << SE) | (a >> (N-SE)), computed at width N.
- Right rotation, OR form: result = (a >> SE) | (a << (N-SE)), computed at width N.
  - Bit i of the result = a[(i+SE) mod N].
- SE = 0 (includes S = 0, S = N, S = k·N): all three results equal a.
  - The implementation must not generate an empty slice or a shift by N; use a generate branch.
- N = 1: all results equal a.
- Latency:
  - Results are computed combinationally from a.
  - They are registered on the clk edge when in_vld=1; out_vld follows in_vld with 1 cycle latency.
  - When in_vld=0: data registers hold their previous values; out_vld=0 on the next cycle.
- rotl_mismatch is registered together with the data, as (rotl_cat_next != rotl_or_next) when in_vld=1. It is cleared when in_vld=0.
- Throughput: one word per cycle, back-to-back in_vld accepted. No backpressure.
- Reset asserted mid-stream: all outputs go to 0 immediately. In-flight data is discarded.
- No X propagation allowed from registers after reset.

Decomposition:
- Shared package circ_shift_pkg holds:
  - A function computing the effective distance (S mod N).
  - A reference rotate-left/rotate-right function (loop over bit index) for use by the testbench model.
- One combinational sub-module, circ_rot_core (parameters N, S), containing the three rotation forms.
- The top module adds the valid pipeline register, the data registers and the mismatch compare.

Test Plan:
- Reset, then N=8, S=3, single valid input a=10110101 → one cycle later rotl_cat=rotl_or=10101101, rotr_or=10110110, out_vld=1, rotl_mismatch=0.
- Walking one, back-to-back valid cycles:
  - a=10000000 → left 00000100, right 00010000.
  - a=00000001 → left 00001000, right 00100000.
  - a=00010000 → left 10000000, right 00000010.
  - Outputs arrive in consecutive cycles.
- Edge patterns:
  - a=00000000 → all 0.
  - a=11111111 → all 11111111.
  - a=01110000 → left 10000011, right 00001110.
  - a=11010001 → left 10001110, right 00111010.
- Hold and reset:
  - in_vld=0 with changing a → data outputs hold and out_vld=0.
  - Assert rst asynchronously between clock edges → all outputs 0 before the next edge.
- Parameter corners, randomized a compared against the package reference function, with rotl_mismatch always 0:
  - S=0 and S=8 at N=8 → outputs equal a.
  - S=11 at N=8 → same results as S=3.
